// File: rtl/irq_timer_pkg.sv
// Shared constants for irq_timer: register offsets, STATUS/ENABLE bit positions and CTRL bits.
package irq_timer_pkg;

    localparam logic [3:0] OFF_RELOAD   = 4'h0;
    localparam logic [3:0] OFF_COUNT    = 4'h2;
    localparam logic [3:0] OFF_STATUS   = 4'h4;
    localparam logic [3:0] OFF_PRESCALE = 4'h6;
    localparam logic [3:0] OFF_ENABLE   = 4'h8;
    localparam logic [3:0] OFF_CTRL     = 4'hA;

    localparam int IRQ_BIT_TIMER = 0;
    localparam int IRQ_BIT_EXT0  = 1;

    localparam int CTRL_BIT_RUN  = 0;

    // Byte offset within the 16-byte window; address bit 0 never matters.
    function automatic logic [3:0] reg_offset(input logic [2:0] word_addr);
        return {word_addr, 1'b0};
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-line 2-flop synchroniser plus a third flop for rising-edge detection.
module irq_edge_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1, sync2, sync3;

    // sync3 clears on reset, so a line already high at release reads as an edge.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

endmodule

// File: rtl/irq_timer.sv
// J1 I/O-bus interrupt controller with down-counting timer.
// Optional prescaler enabled by defining IRQ_TIMER_PRESCALE_EN.
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h1000,
    parameter int          NSRC = 4
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic            io_rd,
    input  logic            io_wr,
    input  logic [15:0]     io_addr,
    input  logic [15:0]     io_dout,
    input  logic [NSRC-1:0] irq_in,
    output logic [15:0]     rd_data,
    output logic            rd_hit,
    output logic            interrupt_request
);

    localparam int SW = NSRC + 1;

    logic [15:0]     reload, count;
    logic [SW-1:0]   status, enable;
    logic            run;
    logic [7:0]      prescale_rd;
    logic            tick;
    logic [NSRC-1:0] ext_rise;
    logic            sel, wr;
    logic [3:0]      off;
    logic            wr_reload, wr_status, wr_enable, wr_ctrl;
    logic            timer_go, underflow;
    logic [SW-1:0]   set_bits, clr_bits;
    logic            unused_ok;

    assign sel       = (io_addr[15:4] == BASE[15:4]);
    assign off       = reg_offset(io_addr[3:1]);
    assign wr        = io_wr & sel;
    assign wr_reload = wr && (off == OFF_RELOAD);
    assign wr_status = wr && (off == OFF_STATUS);
    assign wr_enable = wr && (off == OFF_ENABLE);
    assign wr_ctrl   = wr && (off == OFF_CTRL);
    assign rd_hit    = sel;
    assign unused_ok = ^{io_rd, io_addr[0]};

`ifdef IRQ_TIMER_PRESCALE_EN
    logic [7:0] prescale, pre_cnt;
    logic       wr_prescale;

    assign wr_prescale = wr && (off == OFF_PRESCALE);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            prescale <= 8'h00;
            pre_cnt  <= 8'h00;
        end else begin
            if (wr_prescale)
                prescale <= io_dout[7:0];
            if (wr_prescale || !run || (pre_cnt == prescale))
                pre_cnt <= 8'h00;
            else
                pre_cnt <= pre_cnt + 8'h01;
        end
    end

    assign tick        = (pre_cnt == prescale);
    assign prescale_rd = prescale;
`else
    assign tick        = 1'b1;
    assign prescale_rd = 8'h00;
`endif

    // Clearing the run bit on a tick edge suppresses that tick.
    assign timer_go  = tick & run & ~(wr_ctrl & ~io_dout[CTRL_BIT_RUN]);
    assign underflow = timer_go & (count == 16'h0000);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            reload <= 16'h0000;
            enable <= '0;
            run    <= 1'b0;
        end else begin
            if (wr_reload) reload <= io_dout;
            if (wr_enable) enable <= io_dout[SW-1:0];
            if (wr_ctrl)   run    <= io_dout[CTRL_BIT_RUN];
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            count <= 16'h0000;
        else if (wr_reload)
            count <= io_dout;
        else if (underflow)
            count <= reload;
        else if (timer_go)
            count <= count - 16'h0001;
    end

    irq_edge_sync #(.WIDTH(NSRC)) u_edge_sync (
        .clk    (clk),
        .resetq (resetq),
        .din    (irq_in),
        .rise   (ext_rise)
    );

    always_comb begin
        set_bits = '0;
        set_bits[IRQ_BIT_TIMER]        = underflow;
        set_bits[IRQ_BIT_EXT0 +: NSRC] = ext_rise;
        clr_bits = wr_status ? io_dout[SW-1:0] : '0;
    end

    // New events are ORed in after the clear so a same-edge set always wins.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            status <= '0;
        else
            status <= (status & ~clr_bits) | set_bits;
    end

    assign interrupt_request = |(status & enable);

    always_comb begin
        logic [15:0] status_rd, enable_rd;
        status_rd = 16'h0000;
        enable_rd = 16'h0000;
        status_rd[SW-1:0] = status;
        enable_rd[SW-1:0] = enable;
        rd_data = 16'h0000;
        if (sel) begin
            case (off)
                OFF_RELOAD:   rd_data = reload;
                OFF_COUNT:    rd_data = count;
                OFF_STATUS:   rd_data = status_rd;
                OFF_PRESCALE: rd_data = {8'h00, prescale_rd};
                OFF_ENABLE:   rd_data = enable_rd;
                OFF_CTRL:     rd_data = {15'h0000, run};
                default:      rd_data = 16'h0000;
            endcase
        end
    end

endmodule
